lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator that drives the word-addressed data memory port (en, we, a, wd, rd) on behalf of the core.
- Accepts one byte, halfword or word request at a time over a req/ready handshake.
- Performs byte-lane extraction with sign or zero extension on loads.
- Performs read-modify-write on sub-word stores, because the memory writes whole words only.
- Flags misaligned, out-of-range or illegal accesses without touching memory.

Parameters:
- MEM_WORDS, 64, number of 32-bit words behind the port; byte addresses >= 4*MEM_WORDS are access faults.

Ports:
- clk  in  1  system clock; memory reads update on negedge, writes commit on posedge
- reset  in  1  asynchronous, active-high reset
- req  in  1  core request valid
- store  in  1  1 = store, 0 = load; sampled with req
- funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- ready  out  1  LSU idle, request accepted when req&ready at posedge
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: fault, no memory side effect
- rdata  out  32  extended load result, valid with done
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_a  out  32  word-aligned byte address {addr_q[31:2],2'b00}
- mem_wd  out  32  memory write data
- mem_rd  in  32  memory read data, valid before the posedge ending the READ cycle

Behaviour:
- Reset values:
  - state IDLE
  - ready=1; done=0; err=0; rdata=0
  - mem_en=0; mem_we=0; mem_a=0; mem_wd=0
  - internal addr_q/wdata_q/funct3_q/store_q = 0
- States: IDLE, READ, WRITE, RESP. mem_* outputs decode from registered state and registers only, no combinational path from core inputs.
- IDLE: ready=1.
  - On req, capture addr, wdata, funct3, store.
  - Fault check: halfword with addr[0]=1; word with addr[1:0]!=0; addr >= 4*MEM_WORDS; illegal funct3 (011, 110, 111; and 100/101 with store=1).
  - Fault -> RESP with err=1.
  - Load -> READ.
  - Store word -> WRITE.
  - Store byte/half -> READ.
- READ: mem_en=1, mem_we=0, mem_a driven.
  - At the closing posedge, latch mem_rd into a word register.
  - Load -> RESP.
  - Sub-word store -> WRITE.
- WRITE: mem_en=1, mem_we=1.
  - mem_wd is wdata_q for a word store.
  - For sub-word stores, mem_wd is the latched word with the lanes selected by addr_q[1:0] replaced: byte lane = addr_q[1:0]; half lane = addr_q[1].
  - Write commits at the closing posedge. -> RESP.
- RESP: done=1 for exactly one cycle; err as determined; rdata valid for loads, 0 for stores and faults; mem_en=0. -> IDLE.
- Load extraction:
  - Byte = word >> (8*addr_q[1:0]), half = word >> (16*addr_q[1]).
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- Latency, counted from the accept posedge to the done cycle: load 2 cycles, word store 2, sub-word store 3, fault 1. ready is low from the accept edge until the cycle after done.
- req while not ready is ignored; the core holds it.
- rdata/err hold their value after done until the next RESP; only done is a pulse.
- Reset mid-operation: immediate return to IDLE, mem_we/mem_en drop asynchronously, and no partial write occurs.
  - If reset lands before the WRITE posedge, the memory word is unchanged.
  - A pending request is dropped with no done.
- Address wrap is not supported; the range check precedes any access.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding (IDLE=2'd0, READ=2'd1, WRITE=2'd2, RESP=2'd3)
- Sub-module lsu_lane_align is combinational. It performs byte/half extraction plus extension for loads and lane merge for stores. It is shared by the load and store paths and unit-testable alone.

Test Plan:
- Memory word 3 = 0x80F1_7F23. Load LB at addr 0x0D -> done 2 cycles after accept, rdata=0x0000_007F, err=0. LBU at 0x0F -> rdata=0x0000_0080. LB at 0x0F -> 0xFFFF_FF80.
- Word 5 = 0x1122_3344. SB wdata=0xAB at 0x16 -> READ then WRITE, mem_wd=0x11AB_3344, done on cycle 3. A following LW at 0x14 returns 0x11AB_3344.
- SH wdata=0xBEEF at 0x1A -> word 6 upper half replaced. LH at 0x1A returns 0xFFFF_BEEF; LHU returns 0x0000_BEEF.
- LW at 0x102, then SW at 0x100 (MEM_WORDS=64), then LH at 0x21 -> each completes in 1 cycle with done=1, err=1, rdata=0. mem_en and mem_we stay 0 throughout.
- SB wdata=0x55 at 0x08 with word 2 = 0xFFFF_FFFF; assert reset during READ -> no mem_we pulse, no done; word 2 still 0xFFFF_FFFF; after release ready=1 and all outputs are at reset values.
- Back-to-back: req held high across two SW requests -> second accepted the cycle after the first done. No overlap on mem_we; both words are written.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: RV32I width
//                codes, FSM state encoding and the access-fault check.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Returns 1 when the request must be rejected without touching memory:
  // misaligned half/word, out-of-range address, or an illegal width code.
  function automatic logic access_fault(input logic [2:0]  funct3,
                                        input logic        store,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
    logic fault;
    fault = 1'b0;
    case (funct3)
      F3_B:         fault = 1'b0;
      F3_H:         fault = addr[0];
      F3_W:         fault = |addr[1:0];
      F3_BU, F3_HU: fault = store;     // unsigned widths exist for loads only
      default:      fault = 1'b1;
    endcase
    if (addr >= limit) begin
      fault = 1'b1;
    end
    return fault;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational byte-lane logic. Extracts and extends the
//                addressed byte/half of a loaded word, and merges right-aligned
//                store data into the addressed lanes of an existing word.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] load_word,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword of the loaded word
  always_comb begin
    case (byte_off)
      2'd0:    w_byte = load_word[7:0];
      2'd1:    w_byte = load_word[15:8];
      2'd2:    w_byte = load_word[23:16];
      default: w_byte = load_word[31:24];
    endcase
    w_half = byte_off[1] ? load_word[31:16] : load_word[15:0];
  end

  // Sign- or zero-extend the selected lane according to the width code
  always_comb begin
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   load_data = {24'd0, w_byte};
      F3_HU:   load_data = {16'd0, w_half};
      default: load_data = load_word;
    endcase
  end

  // Replace only the addressed lanes of the old word for sub-word stores
  always_comb begin
    merged_word = old_word;
    case (funct3)
      F3_B:    merged_word[{byte_off, 3'b000} +: 8]     = store_data[7:0];
      F3_H:    merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_ctrl
//  Description : Load/store initiator for a word-addressed data memory.
//                One request at a time; sub-word stores are performed as
//                read-modify-write; faulting requests never reach memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  // First byte address beyond the memory
  localparam logic [31:0] c_addr_limit = 32'(4 * MEM_WORDS);

  lsu_state_t  r_state;
  lsu_state_t  w_next_state;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_store;
  logic [31:0] r_word;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_fault;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // Fault check on the live request so a bad access goes straight to RESP
  assign w_fault = access_fault(funct3, store, addr, c_addr_limit);

  // One lane aligner serves both paths: loads extract from the memory bus
  // during READ, stores merge into the word latched at the end of READ.
  lsu_lane_align u_lane_align (
    .funct3      (r_funct3),
    .byte_off    (r_addr[1:0]),
    .load_word   (mem_rd),
    .load_data   (w_load_data),
    .old_word    (r_word),
    .store_data  (r_wdata),
    .merged_word (w_merged)
  );

  // State register; reset aborts any access and drops the memory strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode from registered state only
  always_comb begin
    w_next_state = r_state;
    ready        = 1'b0;
    done         = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_wd       = 32'd0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (w_fault) begin
            w_next_state = RESP;
          end else if (store && (funct3 == F3_W)) begin
            w_next_state = WRITE;
          end else begin
            w_next_state = READ;  // loads and the read half of sub-word stores
          end
        end
      end
      READ: begin
        mem_en       = 1'b1;
        w_next_state = r_store ? WRITE : RESP;
      end
      WRITE: begin
        mem_en       = 1'b1;
        mem_we       = 1'b1;
        mem_wd       = (r_funct3 == F3_W) ? r_wdata : w_merged;
        w_next_state = RESP;
      end
      RESP: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign mem_a = {r_addr[31:2], 2'b00};
  assign err   = r_err;
  assign rdata = r_rdata;

  // Request capture, read-word latch and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_funct3 <= 3'd0;
      r_store  <= 1'b0;
      r_word   <= 32'd0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req) begin
            r_addr   <= addr;
            r_wdata  <= wdata;
            r_funct3 <= funct3;
            r_store  <= store;
            if (w_fault) begin
              r_err   <= 1'b1;
              r_rdata <= 32'd0;
            end
          end
        end
        READ: begin
          r_word <= mem_rd;
          if (!r_store) begin
            r_err   <= 1'b0;
            r_rdata <= w_load_data;
          end
        end
        WRITE: begin
          r_err   <= 1'b0;
          r_rdata <= 32'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_lsu_mem_ctrl
//  Description : Self-checking bench for lsu_mem_ctrl with a behavioural
//                word memory and a response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        req;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_mem_ctrl #(.MEM_WORDS(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .store  (store),
    .funct3 (funct3),
    .addr   (addr),
    .wdata  (wdata),
    .ready  (ready),
    .done   (done),
    .err    (err),
    .rdata  (rdata),
    .mem_en (mem_en),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          dcyc;
  } resp_t;

  resp_t       exp_q[$];
  resp_t       obs_q[$];
  logic [31:0] wd_exp_q[$];
  logic [31:0] wd_obs_q[$];

  logic [31:0] mem [0:63];

  int n_tests  = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int en_cnt   = 0;
  int we_cnt   = 0;
  int done_cnt = 0;
  resp_t mon_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: read data changes on negedge, writes commit on posedge
  always @(negedge clk) mem_rd <= mem[mem_a[7:2]];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_a[7:2]] <= mem_wd;

  // Monitor: record accepts, write data and responses away from the posedge
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (mem_we) begin
      we_cnt++;
      wd_obs_q.push_back(mem_wd);
    end
    if (done) begin
      done_cnt++;
      mon_r.name  = "";
      mon_r.rdata = rdata;
      mon_r.err   = err;
      mon_r.lat   = cyc - acc_cyc;
      mon_r.dcyc  = cyc;
      obs_q.push_back(mon_r);
    end
    if (req && ready) acc_cyc = cyc;
  end

  function automatic resp_t mk(input string nm, input logic [31:0] rd, input logic er, input int lat);
    resp_t r;
    r.name  = nm;
    r.rdata = rd;
    r.err   = er;
    r.lat   = lat;
    r.dcyc  = 0;
    return r;
  endfunction

  // Present a request and return just after the posedge that accepts it
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    bit seen;
    @(posedge clk); #1;
    req = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: ready stayed %b, required 1", ready);
    end
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_tests++; if (ready  !== 1'b1)  begin n_fail++; $display("FAIL reset_ready: got %b, required 1", ready); end
    n_tests++; if (done   !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_tests++; if (err    !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b, required 0", err); end
    n_tests++; if (rdata  !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h, required 0", rdata); end
    n_tests++; if (mem_en !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_en: got %b, required 0", mem_en); end
    n_tests++; if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
    n_tests++; if (mem_a  !== 32'd0) begin n_fail++; $display("FAIL reset_mem_a: got %h, required 0", mem_a); end
    n_tests++; if (mem_wd !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wd: got %h, required 0", mem_wd); end
  endtask

  task automatic test_loads();
    resp_t e, o;
    mem[3] <= 32'h80F1_7F23;
    exp_q.push_back(mk("lb_0d", 32'h0000_007F, 1'b0, 2));
    issue(1'b0, 3'b000, 32'h0D, 32'd0, 1'b0);
    exp_q.push_back(mk("lbu_0f", 32'h0000_0080, 1'b0, 2));
    issue(1'b0, 3'b100, 32'h0F, 32'd0, 1'b0);
    exp_q.push_back(mk("lb_0f", 32'hFFFF_FF80, 1'b0, 2));
    issue(1'b0, 3'b000, 32'h0F, 32'd0, 1'b0);
    exp_q.push_back(mk("lw_0c", 32'h80F1_7F23, 1'b0, 2));
    issue(1'b0, 3'b010, 32'h0C, 32'd0, 1'b0);
    settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL %s: no done, required rdata=%h err=%b", e.name, e.rdata, e.err);
      end else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
          n_fail++;
          $display("FAIL %s: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                   e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
        end
      end
    end
  endtask

  task automatic test_subword_store();
    resp_t e, o;
    logic [31:0] w, x;
    mem[5] <= 32'h1122_3344;
    mem[6] <= 32'h0000_1234;
    exp_q.push_back(mk("sb_16", 32'd0, 1'b0, 3));
    wd_exp_q.push_back(32'h11AB_3344);
    issue(1'b1, 3'b000, 32'h16, 32'h0000_00AB, 1'b0);
    exp_q.push_back(mk("lw_14", 32'h11AB_3344, 1'b0, 2));
    issue(1'b0, 3'b010, 32'h14, 32'd0, 1'b0);
    exp_q.push_back(mk("sh_1a", 32'd0, 1'b0, 3));
    wd_exp_q.push_back(32'hBEEF_1234);
    issue(1'b1, 3'b001, 32'h1A, 32'h0000_BEEF, 1'b0);
    exp_q.push_back(mk("lh_1a", 32'hFFFF_BEEF, 1'b0, 2));
    issue(1'b0, 3'b001, 32'h1A, 32'd0, 1'b0);
    exp_q.push_back(mk("lhu_1a", 32'h0000_BEEF, 1'b0, 2));
    issue(1'b0, 3'b101, 32'h1A, 32'd0, 1'b0);
    settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL %s: no done, required rdata=%h err=%b", e.name, e.rdata, e.err);
      end else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
          n_fail++;
          $display("FAIL %s: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                   e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
        end
      end
    end
    while (wd_exp_q.size() > 0) begin
      w = wd_exp_q.pop_front();
      n_tests++;
      if (wd_obs_q.size() == 0) begin
        n_fail++; $display("FAIL subword_mem_wd: no write seen, required %h", w);
      end else begin
        x = wd_obs_q.pop_front();
        if (x !== w) begin n_fail++; $display("FAIL subword_mem_wd: got %h, required %h", x, w); end
      end
    end
    n_tests++;
    if (mem[5] !== 32'h11AB_3344) begin n_fail++; $display("FAIL sb_word5: got %h, required 11ab3344", mem[5]); end
    n_tests++;
    if (mem[6] !== 32'hBEEF_1234) begin n_fail++; $display("FAIL sh_word6: got %h, required beef1234", mem[6]); end
  endtask

  task automatic test_faults();
    resp_t e, o;
    int en0, we0;
    en0 = en_cnt;
    we0 = we_cnt;
    exp_q.push_back(mk("lw_102", 32'd0, 1'b1, 1));
    issue(1'b0, 3'b010, 32'h102, 32'd0, 1'b0);
    exp_q.push_back(mk("sw_100", 32'd0, 1'b1, 1));
    issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1'b0);
    exp_q.push_back(mk("lh_21", 32'd0, 1'b1, 1));
    issue(1'b0, 3'b001, 32'h21, 32'd0, 1'b0);
    exp_q.push_back(mk("f3_011", 32'd0, 1'b1, 1));
    issue(1'b0, 3'b011, 32'h00, 32'd0, 1'b0);
    exp_q.push_back(mk("store_bu", 32'd0, 1'b1, 1));
    issue(1'b1, 3'b100, 32'h04, 32'h0000_0011, 1'b0);
    settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL %s: no done, required rdata=%h err=%b", e.name, e.rdata, e.err);
      end else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.lat != e.lat) begin
          n_fail++;
          $display("FAIL %s: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                   e.name, o.rdata, o.err, o.lat, e.rdata, e.err, e.lat);
        end
      end
    end
    n_tests++;
    if (en_cnt != en0 || we_cnt != we0) begin
      n_fail++; $display("FAIL fault_no_access: mem_en cycles=%0d mem_we cycles=%0d, required 0 and 0",
                         en_cnt - en0, we_cnt - we0);
    end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL fault_err_hold: got %b, required 1", err); end
  endtask

  task automatic test_reset_mid_op();
    int we0, done0;
    mem[2] <= 32'hFFFF_FFFF;
    we0   = we_cnt;
    done0 = done_cnt;
    issue(1'b1, 3'b000, 32'h08, 32'h0000_0055, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: mem_en=%b mem_we=%b, required 0 0", mem_en, mem_we);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (we_cnt != we0) begin n_fail++; $display("FAIL midrst_no_write: mem_we cycles=%0d, required 0", we_cnt - we0); end
    n_tests++;
    if (done_cnt != done0) begin n_fail++; $display("FAIL midrst_no_done: done pulses=%0d, required 0", done_cnt - done0); end
    n_tests++;
    if (mem[2] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midrst_word2: got %h, required ffffffff", mem[2]); end
    n_tests++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
      n_fail++; $display("FAIL midrst_core_out: ready=%b done=%b err=%b rdata=%h, required 1 0 0 0",
                         ready, done, err, rdata);
    end
    n_tests++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'd0 || mem_wd !== 32'd0) begin
      n_fail++; $display("FAIL midrst_mem_out: en=%b we=%b a=%h wd=%h, required 0 0 0 0",
                         mem_en, mem_we, mem_a, mem_wd);
    end
  endtask

  task automatic test_back_to_back();
    resp_t e1, e2, o1, o2;
    logic [31:0] x;
    int we0;
    we0 = we_cnt;
    mem[8] <= 32'd0;
    mem[9] <= 32'd0;
    e1 = mk("b2b_sw1", 32'd0, 1'b0, 2);
    e2 = mk("b2b_sw2", 32'd0, 1'b0, 2);
    issue(1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, 1'b1);
    issue(1'b1, 3'b010, 32'h24, 32'h1234_5678, 1'b0);
    settle();
    n_tests++;
    if (obs_q.size() != 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d responses, required 2", obs_q.size());
      obs_q.delete();
    end else begin
      o1 = obs_q.pop_front();
      o2 = obs_q.pop_front();
      n_tests++;
      if (o1.err !== e1.err || o1.rdata !== e1.rdata || o1.lat != e1.lat) begin
        n_fail++; $display("FAIL %s: rdata=%h err=%b lat=%0d, required 0 0 %0d", e1.name, o1.rdata, o1.err, o1.lat, e1.lat);
      end
      n_tests++;
      if (o2.err !== e2.err || o2.rdata !== e2.rdata || o2.lat != e2.lat) begin
        n_fail++; $display("FAIL %s: rdata=%h err=%b lat=%0d, required 0 0 %0d", e2.name, o2.rdata, o2.err, o2.lat, e2.lat);
      end
      n_tests++;
      if ((o2.dcyc - o2.lat) - o1.dcyc != 1) begin
        n_fail++; $display("FAIL b2b_gap: second accepted %0d cycles after first done, required 1",
                           (o2.dcyc - o2.lat) - o1.dcyc);
      end
    end
    n_tests++;
    if (we_cnt - we0 != 2) begin n_fail++; $display("FAIL b2b_we_cycles: got %0d, required 2", we_cnt - we0); end
    wd_exp_q.push_back(32'hCAFE_F00D);
    wd_exp_q.push_back(32'h1234_5678);
    while (wd_exp_q.size() > 0) begin
      x = wd_exp_q.pop_front();
      n_tests++;
      if (wd_obs_q.size() == 0) begin
        n_fail++; $display("FAIL b2b_mem_wd: no write seen, required %h", x);
      end else if (wd_obs_q[0] !== x) begin
        n_fail++; $display("FAIL b2b_mem_wd: got %h, required %h", wd_obs_q[0], x);
        void'(wd_obs_q.pop_front());
      end else begin
        void'(wd_obs_q.pop_front());
      end
    end
    n_tests++;
    if (mem[8] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL b2b_word8: got %h, required cafef00d", mem[8]); end
    n_tests++;
    if (mem[9] !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_word9: got %h, required 12345678", mem[9]); end
  endtask

  initial begin
    reset  = 1'b1;
    req    = 1'b0;
    store  = 1'b0;
    funct3 = 3'd0;
    addr   = 32'd0;
    wdata  = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
    test_reset();
    test_loads();
    test_subword_store();
    test_faults();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time guard so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
